wmem_loader: RTL and testbench
==============================

// Module: wmem_loader
// PURPOSE
//  Upstream feeder for the weight memory. Accepts a byte-serial weight stream
//  (valid/ready), packs ROW_NUM consecutive DATA_WIDTH words into one row word,
//  and issues one row write per packed row at consecutive addresses starting at
//  i_base_addr. Its write outputs connect directly to the wmem write port
//  (i_wr_en / i_wr_addr / i_wr_data).
// PARAMETERS
//  DATA_WIDTH     8            width of one weight element on the stream
//  ROW_NUM        6            elements packed per memory row
//  ADDR_WIDTH     7            weight memory address width (depth 2**ADDR_WIDTH)
//  ROW_WGT_WIDTH  DATA_WIDTH*ROW_NUM   packed row width (derived; do not override)
// PORTS
//  i_clk          in   1              clock; all state updates on posedge
//  i_rst          in   1              synchronous reset, active-high
//  i_start        in   1              start a load job (sampled only in IDLE)
//  i_base_addr    in   ADDR_WIDTH     first row address (sampled with i_start)
//  i_num_rows     in   ADDR_WIDTH+1   rows in the job, 0..2**ADDR_WIDTH (sampled with i_start)
//  i_data_valid   in   1              stream element valid
//  i_data         in   DATA_WIDTH     stream element
//  o_data_ready   out  1              loader accepts the element this cycle
//  o_wr_en        out  1              weight memory write strobe (one cycle per row)
//  o_wr_addr      out  ADDR_WIDTH     weight memory write address
//  o_wr_data      out  ROW_WGT_WIDTH  packed row
//  o_busy         out  1              job in progress (state != IDLE)
//  o_done         out  1              one-cycle pulse: job complete
// BEHAVIOUR
//  Reset: state=IDLE; all outputs 0; element counter, row counter, pack register
//   cleared. Reset mid-job discards the partial row and any pending write; no
//   write is issued in the cycle after reset.
//  FSM: IDLE -> LOAD on i_start with i_num_rows!=0; IDLE -> DONE on i_start with
//   i_num_rows==0 (no writes); LOAD -> DONE when the last element of the last row
//   is accepted; DONE -> IDLE unconditionally after one cycle.
//  o_data_ready = (state==LOAD); it depends only on state, never on i_data_valid.
//   An element is accepted when i_data_valid & o_data_ready.
//  Packing: k-th accepted element of a row (k=0..ROW_NUM-1) goes to bits
//   [k*DATA_WIDTH +: DATA_WIDTH] (element 0 in the LSBs). Element counter wraps
//   ROW_NUM-1 -> 0.
//  Write: on acceptance of element ROW_NUM-1, the next cycle drives o_wr_en=1,
//   o_wr_data = full row, o_wr_addr = base + row_idx (mod 2**ADDR_WIDTH; address
//   wraps silently past the top). Latency: last element accepted in cycle N ->
//   write in cycle N+1. o_wr_en, o_wr_addr, o_wr_data are registered; between
//   writes o_wr_en=0 and addr/data hold their last values.
//  Throughput: one element per cycle; ready stays high during the write cycle, so
//   the stream never stalls on a row boundary.
//  Completion: the final row's write and o_done are asserted in the same cycle
//   (state DONE); o_busy=1 in LOAD and DONE. For a zero-row job o_done pulses in
//   the cycle after i_start with o_wr_en=0.
//  i_start while busy is ignored; i_base_addr and i_num_rows are latched only
//   when a job starts. Stream input is ignored outside LOAD (no acceptance).
//  i_num_rows=2**ADDR_WIDTH fills the whole memory exactly once, wrapping from
//   the top address to 0 when i_base_addr!=0.
// TESTING
//  1 reset, start base=0 rows=1, stream 01..06 back-to-back -> 1 write addr=0
//    data=0x060504030201; o_done in the same cycle; o_busy low next cycle.
//  2 base=5 rows=3, 18 elements, valid toggled 1/0 -> writes at addr 5,6,7 in
//    order; each write exactly 1 cycle after its 6th element; no extra writes.
//  3 base=126 rows=4 -> writes at addr 126,127,0,1; o_done with write to addr 1.
//  4 rows=0 -> o_done 1 cycle after i_start, o_wr_en never high, ready never high.
//  5 assert i_rst after 3 elements of row 0 -> no write; restart base=0 rows=1 with
//    AA..FF -> single write data=0xFFEEDDCCBBAA (stale elements not merged).
//  6 i_start pulsed mid-job with base=9 -> ignored; job completes at original
//    addresses; next i_start accepted only after o_done.

Source files
------------

// File: rtl/wmem_loader.sv
// Packs a DATA_WIDTH element stream into ROW_NUM-wide rows and writes each
// completed row to consecutive weight memory addresses starting at a base.
module wmem_loader #(
    parameter int DATA_WIDTH    = 8,
    parameter int ROW_NUM       = 6,
    parameter int ADDR_WIDTH    = 7,
    parameter int ROW_WGT_WIDTH = DATA_WIDTH * ROW_NUM
) (
    input  logic                     i_clk,
    input  logic                     i_rst,
    input  logic                     i_start,
    input  logic [ADDR_WIDTH-1:0]    i_base_addr,
    input  logic [ADDR_WIDTH:0]      i_num_rows,
    input  logic                     i_data_valid,
    input  logic [DATA_WIDTH-1:0]    i_data,
    output logic                     o_data_ready,
    output logic                     o_wr_en,
    output logic [ADDR_WIDTH-1:0]    o_wr_addr,
    output logic [ROW_WGT_WIDTH-1:0] o_wr_data,
    output logic                     o_busy,
    output logic                     o_done
);

    localparam int EW = (ROW_NUM > 1) ? $clog2(ROW_NUM) : 1;
    localparam logic [EW-1:0]       LAST_ELEM = EW'(ROW_NUM - 1);
    localparam logic [EW-1:0]       ELEM_ONE  = EW'(1);
    localparam logic [ADDR_WIDTH:0] ROW_ONE   = (ADDR_WIDTH + 1)'(1);

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        DONE
    } state_t;

    state_t                   state;
    logic [EW-1:0]            elem_cnt;
    logic [ADDR_WIDTH:0]      row_cnt;
    logic [ADDR_WIDTH:0]      num_rows;
    logic [ADDR_WIDTH-1:0]    base_addr;
    logic [ROW_WGT_WIDTH-1:0] pack;
    logic [ROW_WGT_WIDTH-1:0] row_next;
    logic                     accept;
    logic                     row_end;
    logic                     last_row;

    assign o_data_ready = (state == LOAD);
    assign o_busy       = (state != IDLE);
    assign accept       = i_data_valid && (state == LOAD);
    assign row_end      = (elem_cnt == LAST_ELEM);
    assign last_row     = (row_cnt == num_rows - ROW_ONE);

    // Row as it looks once the element on the stream lands in its slot.
    always_comb begin
        row_next = pack;
        for (int k = 0; k < ROW_NUM; k++) begin
            if (elem_cnt == EW'(k)) begin
                row_next[k*DATA_WIDTH +: DATA_WIDTH] = i_data;
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state     <= IDLE;
            elem_cnt  <= '0;
            row_cnt   <= '0;
            num_rows  <= '0;
            base_addr <= '0;
            pack      <= '0;
            o_wr_en   <= 1'b0;
            o_wr_addr <= '0;
            o_wr_data <= '0;
            o_done    <= 1'b0;
        end else begin
            o_wr_en <= 1'b0;
            o_done  <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (i_start) begin
                        base_addr <= i_base_addr;
                        num_rows  <= i_num_rows;
                        row_cnt   <= '0;
                        elem_cnt  <= '0;
                        pack      <= '0;
                        if (i_num_rows == '0) begin
                            state  <= DONE;
                            o_done <= 1'b1;
                        end else begin
                            state <= LOAD;
                        end
                    end
                end
                LOAD: begin
                    if (accept) begin
                        pack <= row_next;
                        if (row_end) begin
                            elem_cnt  <= '0;
                            row_cnt   <= row_cnt + ROW_ONE;
                            o_wr_en   <= 1'b1;
                            o_wr_addr <= base_addr + row_cnt[ADDR_WIDTH-1:0];
                            o_wr_data <= row_next;
                            // Final write and done share the DONE cycle.
                            if (last_row) begin
                                state  <= DONE;
                                o_done <= 1'b1;
                            end
                        end else begin
                            elem_cnt <= elem_cnt + ELEM_ONE;
                        end
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_wmem_loader.sv
// Randomized scenario bench for wmem_loader with a row-level reference model.
module tb_wmem_loader;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [6:0]  base_in;
    logic [7:0]  rows_in;
    logic        valid;
    logic [7:0]  data;
    logic        ready;
    logic        wr_en;
    logic [6:0]  wr_addr;
    logic [47:0] wr_data;
    logic        busy;
    logic        done;

    wmem_loader dut (
        .i_clk        (clk),
        .i_rst        (rst),
        .i_start      (start),
        .i_base_addr  (base_in),
        .i_num_rows   (rows_in),
        .i_data_valid (valid),
        .i_data       (data),
        .o_data_ready (ready),
        .o_wr_en      (wr_en),
        .o_wr_addr    (wr_addr),
        .o_wr_data    (wr_data),
        .o_busy       (busy),
        .o_done       (done)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int          cyc;
        logic [6:0]  addr;
        logic [47:0] data;
    } wr_t;

    wr_t wr_q[$];
    int  acc_q[$];
    int  done_q[$];
    bit  ready_seen;

    int checks = 0;
    int passes = 0;

    always @(negedge clk) begin
        if (valid === 1'b1 && ready === 1'b1) acc_q.push_back(cyc);
        if (wr_en === 1'b1) wr_q.push_back('{cyc, wr_addr, wr_data});
        if (done === 1'b1) done_q.push_back(cyc);
        if (ready === 1'b1) ready_seen = 1'b1;
    end

    // Row r holds elements r*6 .. r*6+5, element 0 in the low byte.
    function automatic logic [47:0] model_row(input logic [7:0] e[$], input int r);
        logic [47:0] v;
        v = '0;
        for (int k = 0; k < 6; k++) v = v + (48'(e[r*6+k]) << (8*k));
        return v;
    endfunction

    function automatic logic [6:0] model_addr(input int b, input int r);
        return 7'((b + r) % 128);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_obs();
        wr_q.delete();
        acc_q.delete();
        done_q.delete();
        ready_seen = 1'b0;
    endtask

    task automatic do_start(input int b, input int r);
        base_in = 7'(b);
        rows_in = 8'(r);
        start   = 1'b1;
        tick();
        start   = 1'b0;
    endtask

    task automatic send(input logic [7:0] d);
        int n;
        n = 0;
        valid = 1'b1;
        data  = d;
        while (ready !== 1'b1 && n < 50) begin
            tick();
            n++;
        end
        if (n >= 50) begin
            checks++;
            $display("FAIL send_timeout ready=%b required=1", ready);
        end
        tick();
        valid = 1'b0;
    endtask

    task automatic wait_done(input string nm);
        int n;
        n = 0;
        while (done_q.size() == 0 && n < 2000) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (done_q.size() == 0) $display("FAIL %s done_timeout got=0 required=1", nm);
        else passes++;
        @(posedge clk);
        #1;
    endtask

    task automatic run_job(input string nm, input int b, input int r,
                           input int gap, input bit seq);
        logic [7:0] e[$];
        int         last;
        clear_obs();
        for (int i = 0; i < r*6; i++) e.push_back(seq ? 8'(i + 1) : 8'($urandom));
        do_start(b, r);
        for (int i = 0; i < e.size(); i++) begin
            send(e[i]);
            if (gap == 1) tick();
            else if (gap == 2) repeat ($urandom_range(0, 2)) tick();
        end
        wait_done(nm);
        checks++;
        if (busy !== 1'b0) $display("FAIL %s busy_after got=%b required=0", nm, busy);
        else passes++;
        checks++;
        if (acc_q.size() != r*6)
            $display("FAIL %s accepts got=%0d required=%0d", nm, acc_q.size(), r*6);
        else passes++;
        checks++;
        if (wr_q.size() != r)
            $display("FAIL %s writes got=%0d required=%0d", nm, wr_q.size(), r);
        else passes++;
        for (int i = 0; i < wr_q.size() && i < r; i++) begin
            checks++;
            if (wr_q[i].addr !== model_addr(b, i))
                $display("FAIL %s addr[%0d] got=%0d required=%0d",
                         nm, i, wr_q[i].addr, model_addr(b, i));
            else passes++;
            checks++;
            if (wr_q[i].data !== model_row(e, i))
                $display("FAIL %s data[%0d] got=%h required=%h",
                         nm, i, wr_q[i].data, model_row(e, i));
            else passes++;
            if (acc_q.size() > i*6 + 5) begin
                checks++;
                if (wr_q[i].cyc != acc_q[i*6+5] + 1)
                    $display("FAIL %s latency[%0d] got=%0d required=%0d",
                             nm, i, wr_q[i].cyc, acc_q[i*6+5] + 1);
                else passes++;
            end
        end
        if (wr_q.size() > 0) begin
            last = wr_q[wr_q.size()-1].cyc;
            checks++;
            if (done_q.size() != 1 || done_q[0] != last)
                $display("FAIL %s done_cycle got=%0d required=%0d",
                         nm, (done_q.size() > 0) ? done_q[0] : -1, last);
            else passes++;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) tick();
        checks++;
        if ({wr_en, done, busy, ready} !== 4'b0000)
            $display("FAIL reset_flags got=%b required=0000", {wr_en, done, busy, ready});
        else passes++;
        checks++;
        if (wr_addr !== 7'd0) $display("FAIL reset_addr got=%0d required=0", wr_addr);
        else passes++;
        checks++;
        if (wr_data !== 48'd0) $display("FAIL reset_data got=%h required=0", wr_data);
        else passes++;
        rst = 1'b0;
        tick();
    endtask

    task automatic test_basic();
        run_job("basic", 0, 1, 0, 1'b1);
        checks++;
        if (wr_q.size() < 1 || wr_q[0].data !== 48'h060504030201)
            $display("FAIL basic_const got=%h required=060504030201",
                     (wr_q.size() > 0) ? wr_q[0].data : 48'hx);
        else passes++;
    endtask

    task automatic test_toggle();
        run_job("toggle", 5, 3, 1, 1'b0);
    endtask

    task automatic test_wrap();
        run_job("wrap", 126, 4, 0, 1'b0);
    endtask

    task automatic test_zero_rows();
        int sc;
        clear_obs();
        sc = cyc;
        do_start(0, 0);
        repeat (3) tick();
        checks++;
        if (done_q.size() != 1 || done_q[0] != sc + 1)
            $display("FAIL zero_done got=%0d required=%0d",
                     (done_q.size() > 0) ? done_q[0] : -1, sc + 1);
        else passes++;
        checks++;
        if (wr_q.size() != 0) $display("FAIL zero_writes got=%0d required=0", wr_q.size());
        else passes++;
        checks++;
        if (ready_seen) $display("FAIL zero_ready got=1 required=0");
        else passes++;
    endtask

    task automatic test_reset_mid_job();
        logic [7:0] v;
        clear_obs();
        do_start(0, 1);
        for (int i = 0; i < 3; i++) send(8'($urandom));
        rst = 1'b1;
        tick();
        rst = 1'b0;
        repeat (3) tick();
        checks++;
        if (wr_q.size() != 0 || done_q.size() != 0)
            $display("FAIL rstmid_writes got=%0d required=0", wr_q.size() + done_q.size());
        else passes++;
        checks++;
        if (busy !== 1'b0) $display("FAIL rstmid_busy got=%b required=0", busy);
        else passes++;
        clear_obs();
        do_start(0, 1);
        for (int i = 0; i < 6; i++) begin
            v = 8'hAA + 8'(i * 8'h11);
            send(v);
        end
        wait_done("rstmid");
        checks++;
        if (wr_q.size() != 1 || wr_q[0].data !== 48'hFFEEDDCCBBAA || wr_q[0].addr !== 7'd0)
            $display("FAIL rstmid_row got=%h required=ffeeddccbbaa count=%0d",
                     (wr_q.size() > 0) ? wr_q[0].data : 48'hx, wr_q.size());
        else passes++;
    endtask

    task automatic test_start_ignored();
        clear_obs();
        do_start(2, 2);
        for (int i = 0; i < 3; i++) send(8'($urandom));
        base_in = 7'd9;
        rows_in = 8'd5;
        start   = 1'b1;
        tick();
        start   = 1'b0;
        for (int i = 0; i < 9; i++) send(8'($urandom));
        wait_done("ignored");
        checks++;
        if (wr_q.size() != 2) $display("FAIL ignored_count got=%0d required=2", wr_q.size());
        else passes++;
        checks++;
        if (wr_q.size() != 2 || wr_q[0].addr !== 7'd2 || wr_q[1].addr !== 7'd3)
            $display("FAIL ignored_addr got=%0d required=2,3",
                     (wr_q.size() > 0) ? wr_q[0].addr : 7'hx);
        else passes++;
        checks++;
        if (done_q.size() != 1) $display("FAIL ignored_done got=%0d required=1", done_q.size());
        else passes++;
        run_job("after_done", 9, 1, 0, 1'b0);
    endtask

    task automatic test_random();
        for (int j = 0; j < 4; j++)
            run_job("rand", $urandom_range(0, 127), $urandom_range(1, 5), 2, 1'b0);
    endtask

    task automatic test_full_memory();
        run_job("full", 100, 128, 0, 1'b0);
    endtask

    initial begin
        rst     = 1'b1;
        start   = 1'b0;
        base_in = '0;
        rows_in = '0;
        valid   = 1'b0;
        data    = '0;
        #1;
        test_reset();
        test_basic();
        test_toggle();
        test_wrap();
        test_zero_rows();
        test_reset_mid_job();
        test_start_ignored();
        test_random();
        test_full_memory();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
